// File: rtl/wb_stage_unit_pkg.sv
// Shared select codes and state encoding for the writeback stage.
package wb_stage_unit_pkg;

  localparam int unsigned WB_SEL_W = 3;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALU    = 3'b000;
  localparam logic [WB_SEL_W-1:0] WB_SEL_LOAD   = 3'b001;
  localparam logic [WB_SEL_W-1:0] WB_SEL_IMM    = 3'b010;
  localparam logic [WB_SEL_W-1:0] WB_SEL_IADDER = 3'b011;
  localparam logic [WB_SEL_W-1:0] WB_SEL_CSR    = 3'b100;
  localparam logic [WB_SEL_W-1:0] WB_SEL_PC4    = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational writeback source selector; unused codes fall back to the ALU.
module wb_src_mux
  import wb_stage_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic [XLEN-1:0]     alu_i,
  input  logic [XLEN-1:0]     load_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic [XLEN-1:0]     iadder_i,
  input  logic [XLEN-1:0]     csr_i,
  input  logic [XLEN-1:0]     pc4_i,
  output logic [XLEN-1:0]     src_c_o
);

  // Pick the source named by the select code.
  always_comb begin
    src_c_o = alu_i;
    case (sel_i)
      WB_SEL_LOAD:   src_c_o = load_i;
      WB_SEL_IMM:    src_c_o = imm_i;
      WB_SEL_IADDER: src_c_o = iadder_i;
      WB_SEL_CSR:    src_c_o = csr_i;
      WB_SEL_PC4:    src_c_o = pc4_i;
      default:       src_c_o = alu_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_unit.sv
// Writeback stage: source select, load wait with timeout, registered RF write
// port and a writeback-to-execute bypass on ALU operand B.
module wb_stage_unit
  import wb_stage_unit_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RADDR_W      = 5,
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned TO_CNT_W     = 5
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic                flush_in,
  input  logic                stall_in,
  input  logic [2:0]          wb_mux_sel_reg_in,
  input  logic                rf_wr_en_reg_in,
  input  logic [RADDR_W-1:0]  rd_addr_reg_in,
  input  logic [XLEN-1:0]     alu_result_in,
  input  logic [XLEN-1:0]     lu_output_in,
  input  logic [XLEN-1:0]     imm_reg_in,
  input  logic [XLEN-1:0]     iadder_out_reg,
  input  logic [XLEN-1:0]     pc_plus_4_reg_in,
  input  logic [XLEN-1:0]     csr_data_in,
  input  logic                lu_valid_in,
  input  logic                alu_src_reg_in,
  input  logic [XLEN-1:0]     rs2_reg_in,
  input  logic [RADDR_W-1:0]  rs2_addr_reg_in,
  output logic [XLEN-1:0]     alu_2nd_src_mux_out,
  output logic                wb_valid_out,
  output logic                rf_wr_en_out,
  output logic [RADDR_W-1:0]  rf_rd_addr_out,
  output logic [XLEN-1:0]     wb_data_out,
  output logic                load_timeout_out
);

  // Counter value seen during the last permitted WAIT_LOAD cycle.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e             state_q, state_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [RADDR_W-1:0]    pend_rd_q, pend_rd_d;
  logic                  pend_we_q, pend_we_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [RADDR_W-1:0]    rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  load_to_q, load_to_d;

  logic [XLEN-1:0]       src_c;
  logic                  accept_c;
  logic                  is_load_c;
  logic                  to_hit_c;

  wb_src_mux #(.XLEN(XLEN)) u_src_mux (
    .sel_i    (wb_mux_sel_reg_in),
    .alu_i    (alu_result_in),
    .load_i   (lu_output_in),
    .imm_i    (imm_reg_in),
    .iadder_i (iadder_out_reg),
    .csr_i    (csr_data_in),
    .pc4_i    (pc_plus_4_reg_in),
    .src_c_o  (src_c)
  );

  assign ready_out = (state_q == IDLE) && !stall_in && !reset_in;
  assign accept_c  = valid_in && ready_out && !flush_in;
  assign is_load_c = (wb_mux_sel_reg_in == WB_SEL_LOAD);
  assign to_hit_c  = (cnt_q == TO_LAST);

  // Operand B: forward last writeback when it targets rs2, else rs2 or imm.
  always_comb begin
    alu_2nd_src_mux_out = imm_reg_in;
    if (alu_src_reg_in) begin
      if (rf_wr_en_q && (rf_rd_addr_q != '0) && (rf_rd_addr_q == rs2_addr_reg_in)) begin
        alu_2nd_src_mux_out = wb_data_q;
      end else begin
        alu_2nd_src_mux_out = rs2_reg_in;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: park in WAIT_LOAD until data, flush or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c && is_load_c && !lu_valid_in) begin
          state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (flush_in || lu_valid_in || to_hit_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; data wins over timeout, flush wins over both.
  always_comb begin
    cnt_d        = cnt_q;
    pend_rd_d    = pend_rd_q;
    pend_we_d    = pend_we_q;
    wb_valid_d   = 1'b0;
    rf_wr_en_d   = 1'b0;
    load_to_d    = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    wb_data_d    = wb_data_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (!is_load_c || lu_valid_in) begin
            wb_valid_d   = 1'b1;
            rf_wr_en_d   = rf_wr_en_reg_in && (rd_addr_reg_in != '0);
            rf_rd_addr_d = rd_addr_reg_in;
            wb_data_d    = src_c;
          end else begin
            cnt_d     = '0;
            pend_rd_d = rd_addr_reg_in;
            pend_we_d = rf_wr_en_reg_in;
          end
        end
      end
      WAIT_LOAD: begin
        if (flush_in) begin
          cnt_d = '0;
        end else if (lu_valid_in) begin
          wb_valid_d   = 1'b1;
          rf_wr_en_d   = pend_we_q && (pend_rd_q != '0);
          rf_rd_addr_d = pend_rd_q;
          wb_data_d    = lu_output_in;
        end else if (to_hit_c) begin
          load_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q        <= '0;
      pend_rd_q    <= '0;
      pend_we_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      wb_data_q    <= '0;
      load_to_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_rd_q    <= pend_rd_d;
      pend_we_q    <= pend_we_d;
      wb_valid_q   <= wb_valid_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      wb_data_q    <= wb_data_d;
      load_to_q    <= load_to_d;
    end
  end

  assign wb_valid_out     = wb_valid_q;
  assign rf_wr_en_out     = rf_wr_en_q;
  assign rf_rd_addr_out   = rf_rd_addr_q;
  assign wb_data_out      = wb_data_q;
  assign load_timeout_out = load_to_q;

endmodule

// File: doc/wb_stage_unit.md
Name: wb_stage_unit

Overview:
Registered, parametrised writeback stage for the STRV32I core. It selects the writeback source and waits for multi-cycle load data over a valid/ready handshake. It drives the register-file write port one cycle after completion and provides the ALU second-operand mux with a writeback-to-execute bypass. It sits between the execute/load units and the integer register file.

Parameters:
XLEN, 32, datapath width of all data ports
RADDR_W, 5, register address width
LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before abort (>=1)
TO_CNT_W, 5, timeout counter width; must satisfy 2^TO_CNT_W > LOAD_TIMEOUT

Ports:
clk_in  input  1  clock, all state on rising edge
reset_in  input  1  synchronous active-high reset
valid_in  input  1  execute stage presents an instruction
ready_out  output  1  stage can accept (combinational)
flush_in  input  1  kill accepted-this-cycle and pending instruction
stall_in  input  1  hold stage, block acceptance
wb_mux_sel_reg_in  input  3  writeback source select
rf_wr_en_reg_in  input  1  instruction writes rd
rd_addr_reg_in  input  RADDR_W  destination register
alu_result_in, lu_output_in, imm_reg_in, iadder_out_reg, pc_plus_4_reg_in, csr_data_in  input  XLEN each  candidate sources
lu_valid_in  input  1  load data valid this cycle
alu_src_reg_in  input  1  1 = rs2, 0 = imm
rs2_reg_in  input  XLEN  rs2 value from register file
rs2_addr_reg_in  input  RADDR_W  rs2 index, for bypass
alu_2nd_src_mux_out  output  XLEN  ALU operand B (combinational)
wb_valid_out  output  1  registered writeback pulse
rf_wr_en_out  output  1  registered RF write enable
rf_rd_addr_out  output  RADDR_W  registered rd
wb_data_out  output  XLEN  registered write data
load_timeout_out  output  1  one-cycle pulse on load abort

Behaviour:
- Reset: state=IDLE, timeout counter=0, all registered outputs 0.
- Select codes: 000 ALU, 001 LOAD, 010 IMM, 011 IADDER, 100 CSR, 101 PC+4; 110/111 fall back to ALU.
- ready_out = (state==IDLE) && !stall_in && !reset_in. Accept = valid_in && ready_out && !flush_in.
- Non-load accept: on the next edge, wb_valid_out=1, wb_data_out=selected source, rf_rd_addr_out=rd, rf_wr_en_out = rf_wr_en_reg_in && rd!=0. Latency 1.
- Load accept with lu_valid_in in the same cycle completes as a non-load, using lu_output_in. Latency 1.
- Load accept without lu_valid_in: go to WAIT_LOAD, latch rd and wr_en, clear the counter. ready_out stays 0.
- WAIT_LOAD: the counter increments each cycle. When lu_valid_in arrives, register lu_output_in exactly as on completion, then return to IDLE.
- If the counter reaches LOAD_TIMEOUT first: load_timeout_out=1 for one cycle, no write, return to IDLE.
- Simultaneous lu_valid_in and timeout: data wins, no timeout pulse.
- wb_valid_out, rf_wr_en_out and load_timeout_out are single-cycle pulses. wb_data_out and rf_rd_addr_out hold their last value.
- stall_in in WAIT_LOAD does not block completion. A load never loses data.
- flush_in in IDLE: nothing accepted, no write.
- flush_in in WAIT_LOAD: abandon to IDLE with no write and no timeout pulse. A same-cycle lu_valid_in is dropped.
- Bypass: operand = wb_data_out when alu_src_reg_in=1, rf_wr_en_out=1, rf_rd_addr_out!=0 and rf_rd_addr_out==rs2_addr_reg_in. Otherwise rs2_reg_in when alu_src_reg_in=1, else imm_reg_in.
- Reset mid-WAIT_LOAD: immediate IDLE, no write, no pulses.

Decomposition:
- Shared package: 3-bit select localparams (WB_SEL_ALU, WB_SEL_LOAD, WB_SEL_IMM, WB_SEL_IADDER, WB_SEL_CSR, WB_SEL_PC4) and state encodings (IDLE, WAIT_LOAD).
- One sub-module, wb_src_mux: a purely combinational selector producing the source value from the select code. The FSM, counter and bypass logic stay in the top module.

Test Plan:
- ALU op, sel=000, alu=0x0000_1234, rd=5 -> next cycle wb_valid=1, rf_wr_en=1, addr=5, data=0x0000_1234.
- sel=101, pc+4=0x80, rd=0 -> wb_valid=1, rf_wr_en=0; sel=110 with alu=0xA -> data=0xA.
- Load, lu_valid 3 cycles after accept with data 0xDEAD_BEEF, rd=7 -> ready_out low 3 cycles, then one write of 0xDEAD_BEEF to x7.
- Load, lu_valid never asserted, LOAD_TIMEOUT=16 -> load_timeout_out pulses once after 16 WAIT_LOAD cycles, no write, ready_out returns high.
- flush_in 2 cycles into WAIT_LOAD, lu_valid the same cycle -> no write, no timeout pulse, back to IDLE.
- Bypass: write x3=0x55, next cycle alu_src=1, rs2_addr=3, rs2_reg_in=0x11 -> operand 0x55. With rd=0 -> operand 0x11.
